// File: rtl/lsu_pkg.sv
// Shared constants, encodings and lane helpers
// for the MMIO load/store unit.
package lsu_pkg;

  localparam logic [15:0] DMEM_BASE = 16'h2000;
  localparam logic [15:0] LEDR_ADDR = 16'h7000;
  localparam logic [15:0] LEDG_ADDR = 16'h7010;
  localparam logic [15:0] HEXL_ADDR = 16'h7020;
  localparam logic [15:0] HEXH_ADDR = 16'h7024;
  localparam logic [15:0] LCD_ADDR  = 16'h7030;
  localparam logic [15:0] SW_ADDR   = 16'h7800;
  localparam logic [15:0] BTN_ADDR  = 16'h7810;
  localparam int          REG_BYTES = 4;

  typedef enum logic [2:0] {
    OP_B  = 3'b000,
    OP_H  = 3'b001,
    OP_W  = 3'b010,
    OP_BU = 3'b100,
    OP_HU = 3'b101
  } lsu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_e;

  function automatic logic [3:0] byte_en(
    input logic [2:0] op,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = '0;
    unique case (1'b1)
      (op[1:0] == 2'b00): be = 4'b0001 << off;
      (op[1:0] == 2'b01): be = off[1] ? 4'b1100 : 4'b0011;
      (op[1:0] == 2'b10): be = 4'b1111;
      default:            be = '0;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] op,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      (op[1:0] == 2'b01): m = off[0];
      (op[1:0] == 2'b10): m = (off != 2'b00);
      default:            m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] st_rep(
    input logic [2:0]  op,
    input logic [31:0] d
  );
    logic [31:0] r;
    r = d;
    unique case (1'b1)
      (op[1:0] == 2'b00): r = {4{d[7:0]}};
      (op[1:0] == 2'b01): r = {2{d[15:0]}};
      default:            r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ld_ext(
    input logic [2:0]  op,
    input logic [31:0] word,
    input logic [1:0]  off
  );
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    r  = '0;
    unique case (op)
      OP_B:    r = {{24{sh[7]}}, sh[7:0]};
      OP_H:    r = {{16{sh[15]}}, sh[15:0]};
      OP_W:    r = sh;
      OP_BU:   r = {24'h0, sh[7:0]};
      OP_HU:   r = {16'h0, sh[15:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Word-organised data memory: four byte lanes,
// asynchronous read, synchronous write.
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter  int DMEM_BYTES = 8192,
  localparam int AW         = $clog2(DMEM_BYTES) - 2
) (
  input  logic          i_clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem [DMEM_BYTES/REG_BYTES];

  assign o_rdata = mem[i_idx];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/lsu_mmio_ws.sv
// Load/store unit: DMEM with wait states, output
// peripherals and synchronised switch/button inputs.
module lsu_mmio_ws
  import lsu_pkg::*;
#(
  parameter int DMEM_BYTES  = 8192,
  parameter int MEM_WAIT    = 0,
  parameter int NUM_HEX     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [31:0]          i_lsu_addr,
  input  logic [31:0]          i_st_data,
  input  logic                 i_lsu_wren,
  input  logic                 i_lsu_rden,
  input  logic [2:0]           i_lsu_op,
  input  logic [31:0]          i_io_sw,
  input  logic [3:0]           i_io_btn,
  output logic [31:0]          o_ld_data,
  output logic                 o_stall,
  output logic                 o_misaligned,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [7*NUM_HEX-1:0] o_io_hex,
  output logic [31:0]          o_io_lcd
);

  localparam int AW = $clog2(DMEM_BYTES) - 2;

  logic        access;
  logic        is_ld;
  logic        mis;
  logic        upper_ok;
  logic [15:0] a16;
  logic [31:0] doff;
  logic        dmem_hit;
  logic        hit_ledr;
  logic        hit_ledg;
  logic        hit_hexl;
  logic        hit_hexh;
  logic        hit_lcd;
  logic        hit_sw;
  logic        hit_btn;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        io_we;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_rdata;
  logic [31:0] rd_word;

  logic [31:0] ledr_q;
  logic [31:0] ledg_q;
  logic [63:0] hex_q;
  logic [31:0] lcd_q;
  logic [31:0] sw_sync  [SYNC_STAGES];
  logic [3:0]  btn_sync [SYNC_STAGES];

  lsu_state_e  state_q;
  lsu_state_e  state_d;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;

  assign access   = i_lsu_rden | i_lsu_wren;
  assign is_ld    = i_lsu_rden & ~i_lsu_wren;
  assign mis      = access & misaligned(i_lsu_op, i_lsu_addr[1:0]);
  assign upper_ok = (i_lsu_addr[31:16] == 16'h0);
  assign a16      = i_lsu_addr[15:0];
  assign doff     = {16'h0, a16} - {16'h0, DMEM_BASE};

  assign dmem_hit = upper_ok && (a16 >= DMEM_BASE)
                  && (doff < 32'(DMEM_BYTES));
  assign hit_ledr = upper_ok && (a16[15:2] == LEDR_ADDR[15:2]);
  assign hit_ledg = upper_ok && (a16[15:2] == LEDG_ADDR[15:2]);
  assign hit_hexl = upper_ok && (a16[15:2] == HEXL_ADDR[15:2]);
  assign hit_hexh = upper_ok && (a16[15:2] == HEXH_ADDR[15:2]);
  assign hit_lcd  = upper_ok && (a16[15:2] == LCD_ADDR[15:2]);
  assign hit_sw   = upper_ok && (a16[15:2] == SW_ADDR[15:2]);
  assign hit_btn  = upper_ok && (a16[15:2] == BTN_ADDR[15:2]);

  assign be       = byte_en(i_lsu_op, i_lsu_addr[1:0]);
  assign wdata    = st_rep(i_lsu_op, i_st_data);
  assign io_we    = i_lsu_wren & ~mis;
  assign dmem_req = access & dmem_hit & ~mis;

  assign o_misaligned = mis;
  assign o_io_ledr    = ledr_q;
  assign o_io_ledg    = ledg_q;
  assign o_io_lcd     = lcd_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr_q <= '0;
      ledg_q <= '0;
      hex_q  <= '0;
      lcd_q  <= '0;
    end else if (io_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          if (hit_ledr) ledr_q[8*b +: 8] <= wdata[8*b +: 8];
          if (hit_ledg) ledg_q[8*b +: 8] <= wdata[8*b +: 8];
          if (hit_lcd)  lcd_q[8*b +: 8]  <= wdata[8*b +: 8];
          if (hit_hexl && (b < NUM_HEX))
            hex_q[8*b +: 8] <= {1'b0, wdata[8*b +: 7]};
          if (hit_hexh && (b + 4 < NUM_HEX))
            hex_q[32+8*b +: 8] <= {1'b0, wdata[8*b +: 7]};
        end
      end
    end
  end

  always_comb begin
    o_io_hex = '0;
    for (int k = 0; k < NUM_HEX; k++) begin
      o_io_hex[7*k +: 7] = hex_q[8*k +: 7];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sw_sync[s]  <= '0;
        btn_sync[s] <= '0;
      end
    end else begin
      sw_sync[0]  <= i_io_sw;
      btn_sync[0] <= i_io_btn;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sw_sync[s]  <= sw_sync[s-1];
        btn_sync[s] <= btn_sync[s-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A dropped request mid-wait aborts without writing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_stall = 1'b0;
    dmem_we = 1'b0;
    if (MEM_WAIT == 0) begin
      state_d = IDLE;
      cnt_d   = '0;
      dmem_we = dmem_req & i_lsu_wren;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dmem_req) begin
            o_stall = 1'b1;
            state_d = WAIT;
            cnt_d   = 3'(MEM_WAIT - 1);
          end
        end
        WAIT: begin
          if (!dmem_req) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q != 3'd0) begin
            o_stall = 1'b1;
            cnt_d   = cnt_q - 3'd1;
          end else begin
            dmem_we = i_lsu_wren;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (!i_rst_n) begin
      o_stall = 1'b0;
      dmem_we = 1'b0;
    end
  end

  lsu_dmem #(
    .DMEM_BYTES(DMEM_BYTES)
  ) u_dmem (
    .i_clk   (i_clk),
    .i_we    (be & {4{dmem_we}}),
    .i_idx   (doff[AW+1:2]),
    .i_wdata (wdata),
    .o_rdata (dmem_rdata)
  );

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      dmem_hit: rd_word = dmem_rdata;
      hit_ledr: rd_word = ledr_q;
      hit_ledg: rd_word = ledg_q;
      hit_hexl: rd_word = hex_q[31:0];
      hit_hexh: rd_word = hex_q[63:32];
      hit_lcd:  rd_word = lcd_q;
      hit_sw:   rd_word = sw_sync[SYNC_STAGES-1];
      hit_btn:  rd_word = {28'h0, btn_sync[SYNC_STAGES-1]};
      default:  rd_word = '0;
    endcase
  end

  assign o_ld_data = (is_ld & ~mis)
                   ? ld_ext(i_lsu_op, rd_word, i_lsu_addr[1:0])
                   : '0;

endmodule

// File: tb/tb_lsu_mmio_ws.sv
// Bench for lsu_mmio_ws: two instances (0 and 3 wait
// states) against a byte-level reference model.
module tb_lsu_mmio_ws;

  localparam int NH = 8;
  localparam int SS = 2;
  localparam int MW = 3;

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] st;
  logic        wren;
  logic        rden;
  logic [2:0]  op;
  logic [31:0] sw;
  logic [3:0]  btn;
  logic        sel;

  logic [31:0] ld0, ld3, ledr0, ledr3, ledg0, ledg3, lcd0, lcd3;
  logic [55:0] hex0, hex3;
  logic        stl0, stl3, mis0, mis3;

  logic [31:0] ld, ledr, ledg, lcd;
  logic [55:0] hex;
  logic        stl, mis;

  int checks = 0;
  int errors = 0;

  logic [7:0]  bmem [int];
  logic [31:0] m_ledr [2];
  logic [31:0] m_ledg [2];
  logic [31:0] m_lcd  [2];
  logic [63:0] m_hex  [2];

  always #5 clk = ~clk;

  assign ld   = sel ? ld3   : ld0;
  assign ledr = sel ? ledr3 : ledr0;
  assign ledg = sel ? ledg3 : ledg0;
  assign lcd  = sel ? lcd3  : lcd0;
  assign hex  = sel ? hex3  : hex0;
  assign stl  = sel ? stl3  : stl0;
  assign mis  = sel ? mis3  : mis0;

  lsu_mmio_ws #(.MEM_WAIT(0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_lsu_addr(addr),
    .i_st_data(st), .i_lsu_wren(wren & ~sel),
    .i_lsu_rden(rden & ~sel), .i_lsu_op(op),
    .i_io_sw(sw), .i_io_btn(btn), .o_ld_data(ld0),
    .o_stall(stl0), .o_misaligned(mis0), .o_io_ledr(ledr0),
    .o_io_ledg(ledg0), .o_io_hex(hex0), .o_io_lcd(lcd0)
  );

  lsu_mmio_ws #(.MEM_WAIT(MW)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_lsu_addr(addr),
    .i_st_data(st), .i_lsu_wren(wren & sel),
    .i_lsu_rden(rden & sel), .i_lsu_op(op),
    .i_io_sw(sw), .i_io_btn(btn), .o_ld_data(ld3),
    .o_stall(stl3), .o_misaligned(mis3), .o_io_ledr(ledr3),
    .o_io_ledg(ledg3), .o_io_hex(hex3), .o_io_lcd(lcd3)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_size(input logic [2:0] o);
    if (o[1:0] == 2'b00) return 1;
    if (o[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [2:0] o, input logic [31:0] a);
    return (a % m_size(o)) != 0;
  endfunction

  function automatic bit m_dmem(input logic [31:0] a);
    return a >= 32'h2000 && a < 32'h4000;
  endfunction

  function automatic int key(input int s, input logic [31:0] a);
    return s * 65536 + int'(a[15:0]);
  endfunction

  function automatic logic [31:0] m_word(input int s, input logic [31:0] wa);
    case (wa)
      32'h7000: return m_ledr[s];
      32'h7010: return m_ledg[s];
      32'h7020: return m_hex[s][31:0];
      32'h7024: return m_hex[s][63:32];
      32'h7030: return m_lcd[s];
      32'h7800: return sw;
      32'h7810: return {28'h0, btn};
      default:  return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] m_byte(input int s, input logic [31:0] a);
    logic [31:0] w;
    if (m_dmem(a)) return bmem[key(s, a)];
    w = m_word(s, a & ~32'h3);
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] m_load(input int s, input logic [2:0] o,
                                          input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = m_size(o);
    v = 32'h0;
    if (m_mis(o, a)) return 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(m_byte(s, a + k)) << (8 * k));
    if (!o[2] && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
    return v;
  endfunction

  task automatic m_store(input int s, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ba;
    logic [31:0] wa;
    logic [7:0]  b;
    int          ln;
    if (m_mis(o, a)) return;
    for (int k = 0; k < m_size(o); k++) begin
      ba = a + k;
      b  = d[8*k +: 8];
      wa = ba & ~32'h3;
      ln = int'(ba[1:0]);
      if (m_dmem(ba)) bmem[key(s, ba)] = b;
      else case (wa)
        32'h7000: m_ledr[s][8*ln +: 8] = b;
        32'h7010: m_ledg[s][8*ln +: 8] = b;
        32'h7030: m_lcd[s][8*ln +: 8]  = b;
        32'h7020: if (ln < NH) m_hex[s][8*ln +: 8] = {1'b0, b[6:0]};
        32'h7024: if (ln + 4 < NH) m_hex[s][32+8*ln +: 8] = {1'b0, b[6:0]};
        default: ;
      endcase
    end
  endtask

  function automatic logic [55:0] m_hexout(input int s);
    logic [55:0] r;
    r = '0;
    for (int k = 0; k < NH; k++) r[7*k +: 7] = m_hex[s][8*k +: 7];
    return r;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < 2; s++) begin
      m_ledr[s] = '0; m_ledg[s] = '0; m_lcd[s] = '0; m_hex[s] = '0;
    end
  endtask

  task automatic do_op(input string tag, input bit s, input bit wr,
                       input bit rd, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] got);
    int          stalls;
    bit          to;
    logic [31:0] exp_ld;
    bit          exp_mis;
    int          exp_st;
    exp_mis = (wr | rd) && m_mis(o, a);
    exp_st  = (s && (wr | rd) && m_dmem(a) && !m_mis(o, a)) ? MW : 0;
    exp_ld  = m_load(s, o, a);
    @(negedge clk);
    sel = s; wren = wr; rden = rd; op = o; addr = a; st = d;
    stalls = 0;
    to = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!stl) begin
        to = 1'b0;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    got = ld;
    chk({tag, ".timeout"}, to, 1'b0);
    chk({tag, ".stalls"}, stalls, exp_st);
    chk({tag, ".mis"}, mis, exp_mis);
    if (rd && !wr) chk({tag, ".ld"}, got, exp_ld);
    @(posedge clk);
    #1;
    wren = 1'b0;
    rden = 1'b0;
    if (wr) begin
      m_store(s, o, a, d);
      chk({tag, ".ledr"}, ledr, m_ledr[s]);
      chk({tag, ".ledg"}, ledg, m_ledg[s]);
      chk({tag, ".lcd"}, lcd, m_lcd[s]);
      chk({tag, ".hex"}, hex, m_hexout(s));
    end
  endtask

  logic [2:0]  lops [5] = '{B, H, W, BU, HU};
  logic [31:0] got;

  initial begin
    rst_n = 1'b0; sel = 1'b0; wren = 1'b0; rden = 1'b0;
    op = 3'b0; addr = '0; st = '0; sw = '0; btn = '0;
    m_reset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst.ledr", ledr, 0);
      chk("rst.ledg", ledg, 0);
      chk("rst.hex", hex, 0);
      chk("rst.lcd", lcd, 0);
      chk("rst.stall", stl, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_op("sw0", 0, 1, 0, W, 32'h2000, 32'hDEADBEEF, got);
    do_op("lb", 0, 0, 1, B, 32'h2001, 0, got);
    chk("lb.const", got, 32'hFFFFFFBE);
    do_op("lbu", 0, 0, 1, BU, 32'h2003, 0, got);
    chk("lbu.const", got, 32'h000000DE);
    do_op("lhu", 0, 0, 1, HU, 32'h2002, 0, got);
    chk("lhu.const", got, 32'h0000DEAD);

    do_op("sw3", 1, 1, 0, W, 32'h2000, 32'hCAFEF00D, got);
    do_op("lw3", 1, 0, 1, W, 32'h2000, 0, got);
    chk("lw3.const", got, 32'hCAFEF00D);

    do_op("hexw", 0, 1, 0, W, 32'h7020, 32'h44332211, got);
    do_op("hexb", 0, 1, 0, B, 32'h7022, 32'h0000005A, got);
    chk("hexb.d2", hex0[20:14], 7'h5A);
    chk("hexb.d10", hex0[13:0], {7'h22, 7'h11});
    chk("hexb.d3", hex0[27:21], 7'h44);
    do_op("ledrh", 0, 1, 0, H, 32'h7002, 32'h00001234, got);
    chk("ledrh.const", ledr0, 32'h12340000);

    do_op("mislw", 1, 0, 1, W, 32'h2002, 0, got);
    chk("mislw.const", got, 32'h0);
    do_op("missh", 0, 1, 0, H, 32'h7001, 32'h0000ABCD, got);
    chk("missh.ledr", ledr0, 32'h12340000);

    @(negedge clk);
    sw = 32'h000000A5; btn = 4'b1001;
    sel = 1'b0; rden = 1'b1; op = W; addr = 32'h7800;
    for (int k = 0; k <= SS; k++) begin
      #1;
      chk("sync.sw", ld, (k < SS) ? 32'h0 : 32'hA5);
      @(negedge clk);
    end
    addr = 32'h7810;
    #1;
    chk("sync.btn", ld, 32'h9);
    rden = 1'b0;
    do_op("swro", 0, 1, 0, W, 32'h7800, 32'hFFFFFFFF, got);
    do_op("swrd", 0, 0, 1, W, 32'h7800, 0, got);
    chk("swrd.const", got, 32'hA5);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++)
        do_op("init", s[0], 1, 0, W, 32'h2000 + 4 * i, $urandom, got);
      do_op("initend", s[0], 1, 0, W, 32'h3FFC, $urandom, got);
    end
    do_op("end", 1, 0, 1, W, 32'h4000, 0, got);
    do_op("below", 1, 0, 1, W, 32'h1FFC, 0, got);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [2:0]  o;
      bit          s, wr, rd;
      int          r, kind;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: a = 32'h2000 + $urandom_range(0, 63);
        5: a = 32'h3FFC + $urandom_range(0, 3);
        6: a = 32'h7000 + ($urandom_range(0, 3) << 4) + $urandom_range(0, 7);
        7: a = 32'h7800 + ($urandom_range(0, 1) << 4) + $urandom_range(0, 3);
        8: a = 32'h00012000 + $urandom_range(0, 63);
        default: a = $urandom_range(0, 1) ? 32'h4000 + $urandom_range(0, 7)
                                          : 32'h1FF8 + $urandom_range(0, 7);
      endcase
      s    = $urandom_range(0, 1) == 1;
      kind = $urandom_range(0, 9);
      rd   = kind < 5 || kind == 9;
      wr   = kind >= 5;
      o    = wr ? lops[$urandom_range(0, 2)] : lops[$urandom_range(0, 4)];
      do_op("rnd", s, wr, rd, o, a, $urandom, got);
    end

    do_op("preled", 1, 1, 0, W, 32'h7000, 32'hFFFF0000, got);
    @(negedge clk);
    sel = 1'b1; wren = 1'b1; rden = 1'b0; op = W;
    addr = 32'h2000; st = 32'h13572468;
    #1;
    chk("rstw.stall1", stl, 1);
    @(negedge clk);
    rst_n = 1'b0;
    wren = 1'b0;
    #1;
    chk("rstw.stall", stl, 0);
    chk("rstw.ledr", ledr, 0);
    chk("rstw.ledg", ledg, 0);
    chk("rstw.hex", hex, 0);
    chk("rstw.lcd", lcd, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_op("rstw.rd", 1, 0, 1, W, 32'h2000, 0, got);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
